// File: rtl/axi_sram_responder_if.sv
// AXI3 signal bundle between the CPU bridge (master) and the SRAM responder (slave).
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// the source keeps valid and payload stable from raising valid until that edge.
interface axi_sram_responder_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by a word-addressed, byte-enabled SRAM; serves one
// transaction at a time, with reads taking priority over writes.
module axi_sram_responder #(
    parameter int unsigned MEM_AW      = 12,
    parameter logic [1:0]  RESP_OKAY   = 2'b00,
    parameter logic [1:0]  RESP_SLVERR = 2'b10
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_sram_responder_if.slave  bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  id_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [1:0]  burst_q;
    logic        err_q;

    logic [31:0] mem [0:(2**MEM_AW)-1];

    logic [31:0] step;
    logic [31:0] container;
    logic [31:0] wrap_mask;
    logic [31:0] next_addr;
    logic        ar_hs;
    logic        aw_hs;
    logic        r_hs;
    logic        w_hs;
    logic        b_hs;
    logic        mem_we;
    logic        unused_ok;

    assign bus.arready = aresetn & (state == IDLE);
    assign bus.awready = aresetn & (state == IDLE) & ~bus.arvalid;

    assign ar_hs  = bus.arvalid & bus.arready;
    assign aw_hs  = bus.awvalid & bus.awready;
    assign r_hs   = bus.rvalid & bus.rready;
    assign w_hs   = bus.wvalid & bus.wready;
    assign b_hs   = bus.bvalid & bus.bready;
    assign mem_we = (state == WR) & w_hs;

    assign dbg_state = state;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};

    // size_q is already clamped to 2, so oversize transfers still step by a word.
    always_comb begin
        step      = 32'd1 << size_q;
        container = ({28'd0, len_q} + 32'd1) << size_q;
        wrap_mask = container - 32'd1;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q + step;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[addr_q[MEM_AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            id_q       <= 4'd0;
            len_q      <= 4'd0;
            beat_q     <= 4'd0;
            addr_q     <= 32'd0;
            size_q     <= 2'd0;
            burst_q    <= 2'd0;
            err_q      <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.rlast  <= 1'b0;
            bus.rid    <= 4'd0;
            bus.rdata  <= 32'd0;
            bus.rresp  <= 2'b00;
            bus.wready <= 1'b0;
            bus.bvalid <= 1'b0;
            bus.bid    <= 4'd0;
            bus.bresp  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr_q     <= bus.araddr;
                        len_q      <= bus.arlen;
                        size_q     <= (bus.arsize > 3'd2) ? 2'd2 : bus.arsize[1:0];
                        burst_q    <= bus.arburst;
                        beat_q     <= 4'd0;
                        bus.rid    <= bus.arid;
                        bus.rdata  <= mem[bus.araddr[MEM_AW+1:2]];
                        bus.rresp  <= (bus.arsize > 3'd2) ? RESP_SLVERR : RESP_OKAY;
                        bus.rlast  <= (bus.arlen == 4'd0);
                        bus.rvalid <= 1'b1;
                        state      <= RD;
                    end else if (aw_hs) begin
                        id_q       <= bus.awid;
                        addr_q     <= bus.awaddr;
                        len_q      <= bus.awlen;
                        size_q     <= (bus.awsize > 3'd2) ? 2'd2 : bus.awsize[1:0];
                        burst_q    <= bus.awburst;
                        beat_q     <= 4'd0;
                        err_q      <= (bus.awsize > 3'd2);
                        bus.wready <= 1'b1;
                        state      <= WR;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        if (beat_q == len_q) begin
                            bus.rvalid <= 1'b0;
                            bus.rlast  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            addr_q    <= next_addr;
                            beat_q    <= beat_q + 4'd1;
                            bus.rdata <= mem[next_addr[MEM_AW+1:2]];
                            bus.rlast <= (beat_q + 4'd1 == len_q);
                        end
                    end
                end
                WR: begin
                    // The beat count, not wlast, ends the burst; a misplaced wlast only flags an error.
                    if (w_hs) begin
                        if (beat_q == len_q) begin
                            bus.wready <= 1'b0;
                            bus.bvalid <= 1'b1;
                            bus.bid    <= id_q;
                            bus.bresp  <= (err_q | ~bus.wlast) ? RESP_SLVERR : RESP_OKAY;
                            state      <= WB;
                        end else begin
                            err_q  <= err_q | bus.wlast;
                            addr_q <= next_addr;
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                WB: begin
                    if (b_hs) begin
                        bus.bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
